// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - bin subtractor, BITS_PER_CYCLE bits per clock, LSB slice first.
// Define SERIAL_SUBTRACTOR_OVERFLOW_EN to add the signed-overflow output.
module serial_subtractor #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned K     = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(K + 1);

    initial begin
        if (WIDTH < 2) $fatal(1, "serial_subtractor: WIDTH must be >= 2");
        if (WIDTH % BITS_PER_CYCLE != 0)
            $fatal(1, "serial_subtractor: BITS_PER_CYCLE must divide WIDTH");
    end

    typedef enum logic [0:0] {StIdle, StRun} state_t;

    state_t                    state_q;
    logic [WIDTH-1:0]          a_q;
    logic [WIDTH-1:0]          b_q;
    logic                      c_q;
    logic [WIDTH-1:0]          acc_q;
    logic [CNT_W-1:0]          cnt_q;

    logic [BITS_PER_CYCLE-1:0] slice;
    logic                      chain;
    logic                      slice_bo;
    logic [WIDTH+BITS_PER_CYCLE-1:0] acc_wide;
    logic [WIDTH-1:0]          acc_next;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic                      msb_cin;
`endif

    // Ripple the borrow through this cycle's slice of full-subtractor cells.
    always_comb begin
        chain = c_q;
        slice = '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        msb_cin = 1'b0;
`endif
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            slice[i] = a_q[i] ^ b_q[i] ^ chain;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            if (i == int'(BITS_PER_CYCLE) - 1) msb_cin = chain;
`endif
            chain = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & chain);
        end
        slice_bo = chain;
        // New slice enters at the top; after K cycles slice 0 sits at the LSB.
        acc_wide = {slice, acc_q};
        acc_next = acc_wide[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            difference <= '0;
            borrow     <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            overflow   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        c_q     <= bin;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    a_q   <= a_q >> BITS_PER_CYCLE;
                    b_q   <= b_q >> BITS_PER_CYCLE;
                    c_q   <= slice_bo;
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(K - 1)) begin
                        difference <= acc_next;
                        borrow     <= slice_bo;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                        overflow   <= msb_cin ^ slice_bo;
`endif
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Parametrised multi-cycle N-bit subtractor that computes difference = a - b - bin. It uses an internal chain of BITS_PER_CYCLE full-subtractor cells, processing BITS_PER_CYCLE bits per clock, LSB first. A start/busy/done handshake fronts the block, which lets wide subtractions share a small datapath in the adders library. It is the sequential, width-generalised successor of the single-bit full subtractor.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 2.
BITS_PER_CYCLE, 1, bits processed per clock; must divide WIDTH exactly, giving K = WIDTH/BITS_PER_CYCLE run cycles.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only while busy=0.
a  input  WIDTH  minuend; captured on the accepting edge.
b  input  WIDTH  subtrahend; captured on the accepting edge.
bin  input  1  borrow-in; captured on the accepting edge.
busy  output  1  high while a subtraction is in progress.
done  output  1  one-cycle pulse when the result is valid.
difference  output  WIDTH  result; held until the next completion.
borrow  output  1  final borrow-out; held with difference.

Behaviour:
- Reset is asynchronous and active-high. On rst=1, immediately: state=IDLE, busy=0, done=0, difference=0, borrow=0, bit counter=0, operand and partial registers=0.
- FSM states: IDLE and RUN.
- IDLE -> RUN on a clk edge with start=1. That edge latches a, b and bin, sets busy=1 and clears the counter.
- RUN: each edge consumes the next BITS_PER_CYCLE bits of the latched operands, LSB slice first.
  - The slice borrow-in is the previous slice's borrow-out; for slice 0 it is the latched bin.
  - Per-bit cell: d = x ^ y ^ c; bo = (~x & y) | (~(x ^ y) & c).
  - The slice result shifts into the partial-result register and the counter increments.
- Completion: on the K-th RUN edge, difference and borrow load the final value, done=1 for exactly that one cycle, busy=0 and the state returns to IDLE.
- Latency: done is high in the cycle following the K-th edge after the accepting edge. With WIDTH=8 and BITS_PER_CYCLE=1, that is 8 edges.
- Back-to-back operation: start=1 while done=1 is accepted on that edge, so there is no dead cycle between operations.
- start while busy=1 is ignored; operands are not re-latched.
- Input changes on a, b or bin during RUN have no effect on the result.
- difference and borrow update only at completion. Intermediate slices are never visible on the outputs.
- Arithmetic is modular 2^WIDTH. borrow=1 iff a < b + bin, treating the operands as unsigned.
- Reset mid-operation aborts the operation. Outputs return to their reset values and no done pulse is produced.
- Elaboration checks: WIDTH % BITS_PER_CYCLE != 0 or WIDTH < 2 must trigger $error/$fatal in an initial block.

Optional Feature:
Macro SERIAL_SUBTRACTOR_OVERFLOW_EN.
- Defined: adds output port overflow (1 bit). It is the signed two's-complement overflow of a - b - bin, computed as borrow-in XOR borrow-out of the MSB cell. It resets to 0, updates only at completion alongside difference, and is held until the next completion.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, BITS_PER_CYCLE=1; a=0x05, b=0x03, bin=0, pulse start -> after 8 edges done pulses for 1 cycle with difference=0x02, borrow=0; busy is high for exactly 8 cycles.
- a=0x00, b=0x01, bin=0 -> difference=0xFF, borrow=1. Then a=0x00, b=0x00, bin=1 -> difference=0xFF, borrow=1.
- OVERFLOW_EN defined:
  - a=0x80, b=0x01, bin=0 -> difference=0x7F, borrow=0, overflow=1.
  - a=0x7F, b=0x01 -> difference=0x7E, overflow=0.
- Start while busy:
  - Start with a=0x10, b=0x01, then start=1 with a=0xAA, b=0x55 at cycle 3 -> result is 0x0F; the second request is ignored.
  - Start with start held through done -> the next operation is accepted on the done cycle.
- Reset mid-op: assert rst at cycle 4 of a run -> busy, done, difference and borrow drop to 0 at once. No done pulse follows, and a new start completes normally.
- WIDTH=16, BITS_PER_CYCLE=4; a=0x1234, b=0x0235, bin=1 -> done after 4 edges with difference=0x0FFE, borrow=0. Also sweep all 8 single-bit input combinations (a, b, bin) in the LSB against a reference model.
